mem_stage_pip: RTL and testbench
================================

Name: mem_stage_pip

Overview:
- MEM pipeline stage. Consumes the EX/MEM register outputs: address, store data, funct3 and control.
- Drives a request/grant/rvalid data-memory bus for byte, half and word loads and stores.
- Stalls the upstream pipeline while a memory access is outstanding.
- Registers results into MEM/WB and supplies the MEM-stage forwarding value back to EX.

Parameters:
- XLEN, 32, datapath width (only 32 supported)
- MISALIGN_TRAP, 1, 1: misaligned accesses are suppressed and flagged. 0: the address low bits are forced to zero and the access proceeds.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- pc_in  in  32  PC from EX/MEM
- alu_result_in  in  32  effective address or ALU result
- rs2_data_in  in  32  store data
- funct3_in  in  3  access size and sign
- rd_in  in  5  destination register
- wb_sel_in  in  2  writeback select, passed through
- mem_read_in  in  1  load
- mem_write_in  in  1  store
- reg_write_in  in  1  register write enable
- mem_to_reg_in  in  1  writeback from memory
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address ({alu_result_in[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data word
- stall_out  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- forward_data_mem  out  32  equals alu_result_in, combinational
- pc_out, alu_result_out  out  32  MEM/WB fields
- mem_data_out  out  32  extended load data
- rd_out  out  5  MEM/WB field
- wb_sel_out  out  2  MEM/WB field
- reg_write_out, mem_to_reg_out  out  1  MEM/WB fields
- misalign_out  out  1  one-cycle flag in MEM/WB

Behaviour:
- Reset: state=IDLE, every registered output 0, dmem_req=0.
- Memory op:
  - mem_op = mem_read_in | mem_write_in. If both are set, the op is treated as a read.
- Misalignment:
  - misaligned = (funct3[1:0]==01 & addr[0]) | (funct3[1:0]==10 & addr[1:0]!=0).
  - With MISALIGN_TRAP=1 a misaligned op issues no request and does not stall.
  - MEM/WB then captures reg_write_out=0 and misalign_out=1.
- Stores:
  - SB: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{rs2[15:0]}}.
  - SW: be=4'b1111, wdata=rs2.
  - dmem_be=0 for reads and when idle.
- Load extraction: select the byte or half lane by addr[1:0] or addr[1].
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Other funct3 values behave as LW.
- FSM IDLE:
  - dmem_req = mem_op & ~misaligned.
  - Write with gnt: completes this cycle, stays in IDLE.
  - Read with gnt: go to WAIT_R.
  - No gnt: remain in IDLE with request held and address, wdata and be stable.
- FSM WAIT_R:
  - dmem_req=0.
  - On rvalid: completes this cycle, capture extended data, go to IDLE.
  - rvalid while in IDLE is ignored.
- Stall rule:
  - stall_out = mem_op & ~misaligned & ~complete.
  - complete = (IDLE & gnt & write) | (WAIT_R & rvalid).
  - Minimum load latency is 2 cycles (req/gnt cycle, then rvalid cycle). Zero-wait store is 1 cycle with no stall.
- MEM/WB update, each cycle:
  - stall_out=0: load all fields. mem_data_out = extended rdata on load completion, else 0.
  - stall_out=1: bubble. reg_write_out=0 and misalign_out=0, other fields hold.
- Non-memory instructions pass through in one cycle with no bus activity.
- Reset mid-access: rst in WAIT_R returns to IDLE. Any later rvalid is dropped and nothing is written back.

Test Plan:
- Non-mem pass-through: reg_write_in=1, alu_result_in=0x1234, rd_in=5 → next cycle alu_result_out=0x1234, rd_out=5, reg_write_out=1, stall_out never asserted.
- SB zero-wait: addr=0x103, rs2=0xAABBCCDD, gnt same cycle → dmem_be=4'b1000, dmem_wdata=0xDDDDDDDD, dmem_addr=0x100, stall_out=0.
- LB with 2-cycle rvalid delay: addr=0x202, rdata=0x00800000 → stall_out high for 2 cycles, mem_data_out=0xFFFFFF80. Repeat as LBU → 0x00000080.
- Grant withheld 3 cycles on SW: dmem_req held with stable addr/wdata/be, stall_out=1 each cycle, three bubbles (reg_write_out=0), completion on the gnt cycle.
- Misaligned LW at 0x06 → dmem_req=0, stall_out=0, next cycle misalign_out=1 and reg_write_out=0.
- Reset while in WAIT_R, then rvalid=1 → state IDLE, no MEM/WB load, all outputs 0.

Source files
------------

// File: rtl/mem_stage_pip.sv
// MEM pipeline stage: drives a request/grant/rvalid data bus for byte, half and
// word accesses, stalls upstream while an access is outstanding, registers MEM/WB.
module mem_stage_pip #(
    parameter int XLEN          = 32,
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic            clk,
    input  logic            rst,

    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] rs2_data_in,
    input  logic [2:0]      funct3_in,
    input  logic [4:0]      rd_in,
    input  logic [1:0]      wb_sel_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic            reg_write_in,
    input  logic            mem_to_reg_in,

    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,

    output logic            stall_out,
    output logic [XLEN-1:0] forward_data_mem,

    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] mem_data_out,
    output logic [4:0]      rd_out,
    output logic [1:0]      wb_sel_out,
    output logic            reg_write_out,
    output logic            mem_to_reg_out,
    output logic            misalign_out
);

    typedef enum logic {
        IDLE,
        WAIT_R
    } state_t;

    state_t state, state_nxt;

    logic            mem_op;
    logic            is_read;
    logic            is_write;
    logic            misaligned_raw;
    logic            misaligned;
    logic            load_done;
    logic            complete;
    logic [1:0]      lane;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_ext;

    // A simultaneous read and write request is resolved as a read.
    assign mem_op   = mem_read_in | mem_write_in;
    assign is_read  = mem_read_in;
    assign is_write = mem_write_in & ~mem_read_in;

    assign misaligned_raw = ((funct3_in[1:0] == 2'b01) && alu_result_in[0]) ||
                            ((funct3_in[1:0] == 2'b10) && (alu_result_in[1:0] != 2'b00));
    assign misaligned     = MISALIGN_TRAP && mem_op && misaligned_raw;

    assign forward_data_mem = alu_result_in;
    assign dmem_addr        = {alu_result_in[XLEN-1:2], 2'b00};

    // Without trapping, the lane is snapped to the natural alignment of the access.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        lane = alu_result_in[1:0];
        if (!MISALIGN_TRAP) begin
            case (funct3_in[1:0])
                2'b01:   lane = {alu_result_in[1], 1'b0};
                2'b10:   lane = 2'b00;
                default: lane = alu_result_in[1:0];
            endcase
        end
    end

    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_be    = 4'b0000;
        case (funct3_in[1:0])
            2'b00:   dmem_wdata = {4{rs2_data_in[7:0]}};
            2'b01:   dmem_wdata = {2{rs2_data_in[15:0]}};
            default: dmem_wdata = rs2_data_in;
        endcase
        if (!rst && (state == IDLE) && mem_op && !misaligned) begin
            dmem_req = 1'b1;
            dmem_we  = is_write;
            if (is_write) begin
                case (funct3_in[1:0])
                    2'b00:   dmem_be = 4'b0001 << lane;
                    2'b01:   dmem_be = 4'b0011 << {lane[1], 1'b0};
                    default: dmem_be = 4'b1111;
                endcase
            end
        end
    end

    always_comb begin
        case (lane)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_in)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_ext = {24'b0, ld_byte};
            3'b101:  load_ext = {16'b0, ld_half};
            default: load_ext = dmem_rdata;
        endcase
    end

    // rvalid only counts in WAIT_R; a stray rvalid while idle is ignored.
    assign load_done = (state == WAIT_R) && dmem_rvalid;
    assign complete  = (dmem_req && dmem_gnt && is_write) || load_done;
    assign stall_out = !rst && mem_op && !misaligned && !complete;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (dmem_req && dmem_gnt && is_read) state_nxt = WAIT_R;
            WAIT_R: if (dmem_rvalid)                     state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every field samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pc_out         <= '0;
            alu_result_out <= '0;
            mem_data_out   <= '0;
            rd_out         <= '0;
            wb_sel_out     <= '0;
            reg_write_out  <= 1'b0;
            mem_to_reg_out <= 1'b0;
            misalign_out   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!stall_out) begin
                pc_out         <= pc_in;
                alu_result_out <= alu_result_in;
                mem_data_out   <= load_done ? load_ext : '0;
                rd_out         <= rd_in;
                wb_sel_out     <= wb_sel_in;
                reg_write_out  <= reg_write_in & ~misaligned;
                mem_to_reg_out <= mem_to_reg_in;
                misalign_out   <= misaligned;
            end else begin
                // Bubble into WB: kill the write, hold everything else.
                reg_write_out  <= 1'b0;
                misalign_out   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_pip.sv
// Self-checking bench for mem_stage_pip: directed steps followed by randomized
// operations compared against a transaction-level reference model.
module tb_mem_stage_pip;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [1:0]  wbs;
        logic        rd_en;
        logic        wr_en;
        logic        rw;
        logic        m2r;
    } op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in, alu_result_in, rs2_data_in;
    logic [2:0]  funct3_in;
    logic [4:0]  rd_in;
    logic [1:0]  wb_sel_in;
    logic        mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_out;
    logic [31:0] forward_data_mem, pc_out, alu_result_out, mem_data_out;
    logic [4:0]  rd_out;
    logic [1:0]  wb_sel_out;
    logic        reg_write_out, mem_to_reg_out, misalign_out;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_alu_hold = '0;
    logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  st_f3 [3] = '{3'b000, 3'b001, 3'b010};

    mem_stage_pip dut (
        .clk(clk), .rst(rst),
        .pc_in(pc_in), .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in),
        .funct3_in(funct3_in), .rd_in(rd_in), .wb_sel_in(wb_sel_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .stall_out(stall_out), .forward_data_mem(forward_data_mem),
        .pc_out(pc_out), .alu_result_out(alu_result_out), .mem_data_out(mem_data_out),
        .rd_out(rd_out), .wb_sel_out(wb_sel_out), .reg_write_out(reg_write_out),
        .mem_to_reg_out(mem_to_reg_out), .misalign_out(misalign_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic op_t mk(input logic [31:0] pc, addr, rs2, input logic [2:0] f3,
                               input logic [4:0] rd, input logic rd_en, wr_en, rw, m2r);
        op_t o;
        o.pc = pc; o.addr = addr; o.rs2 = rs2; o.f3 = f3; o.rd = rd; o.wbs = 2'b01;
        o.rd_en = rd_en; o.wr_en = wr_en; o.rw = rw; o.m2r = m2r;
        return o;
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_mis(input op_t op);
        int n;
        n = size_of(op.f3);
        return (op.rd_en || op.wr_en) && ((int'(op.addr[1:0]) % n) != 0);
    endfunction

    function automatic logic [3:0] exp_be(input op_t op);
        int n, off;
        n   = size_of(op.f3);
        off = (n == 4) ? 0 : int'(op.addr[1:0]);
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] exp_wdata(input op_t op);
        case (size_of(op.f3))
            1:       return 32'(op.rs2[7:0]) * 32'h0101_0101;
            2:       return 32'(op.rs2[15:0]) * 32'h0001_0001;
            default: return op.rs2;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input op_t op, input logic [31:0] rdata);
        int n, off;
        logic [31:0] mask, val;
        n    = size_of(op.f3);
        off  = (n == 4) ? 0 : int'(op.addr[1:0]);
        mask = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
        val  = (rdata >> (8 * off)) & mask;
        if (!op.f3[2] && n < 4 && val[8 * n - 1]) val = val | ~mask;
        return val;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input op_t op, input logic gnt, input logic rv, input logic [31:0] rdata);
        pc_in = op.pc; alu_result_in = op.addr; rs2_data_in = op.rs2;
        funct3_in = op.f3; rd_in = op.rd; wb_sel_in = op.wbs;
        mem_read_in = op.rd_en; mem_write_in = op.wr_en;
        reg_write_in = op.rw; mem_to_reg_in = op.m2r;
        dmem_gnt = gnt; dmem_rvalid = rv; dmem_rdata = rdata;
    endtask

    task automatic post(input op_t op, input bit stalled, input logic [31:0] data);
        if (stalled) begin
            check("bubble_rw", 32'(reg_write_out), 32'd0);
            check("bubble_mis", 32'(misalign_out), 32'd0);
            check("bubble_hold", alu_result_out, exp_alu_hold);
        end else begin
            check("pc_out", pc_out, op.pc);
            check("alu_out", alu_result_out, op.addr);
            check("rd_out", 32'(rd_out), 32'(op.rd));
            check("wb_sel", 32'(wb_sel_out), 32'(op.wbs));
            check("reg_write", 32'(reg_write_out), 32'(op.rw & ~is_mis(op)));
            check("mem_to_reg", 32'(mem_to_reg_out), 32'(op.m2r));
            check("misalign", 32'(misalign_out), 32'(is_mis(op)));
            check("mem_data", mem_data_out, data);
            exp_alu_hold = op.addr;
        end
    endtask

    // Runs one instruction to completion: grant after gnt_dly idle cycles, rvalid
    // rv_dly cycles after the grant cycle. Returns the number of stalled cycles.
    task automatic run_op(input op_t op, input int gnt_dly, input int rv_dly,
                          input logic [31:0] rdata, input bit rv_noise, output int stalls);
        bit mem, rd, wr, mis, req, g, st, v;
        int last;
        mem  = op.rd_en | op.wr_en;
        rd   = op.rd_en;
        wr   = op.wr_en & ~op.rd_en;
        mis  = is_mis(op);
        req  = mem && !mis;
        last = req ? gnt_dly : 0;
        stalls = 0;
        for (int c = 0; c <= last; c++) begin
            g = req && (c == gnt_dly);
            @(negedge clk);
            drive(op, g, rv_noise, rdata);
            #1;
            check("req", 32'(dmem_req), 32'(req));
            check("fwd", forward_data_mem, op.addr);
            check("be", 32'(dmem_be), (req && wr) ? 32'(exp_be(op)) : 32'd0);
            if (req) begin
                check("addr", dmem_addr, {op.addr[31:2], 2'b00});
                check("we", 32'(dmem_we), 32'(wr));
                if (wr) check("wdata", dmem_wdata, exp_wdata(op));
            end
            st = req && !(g && wr);
            check("stall", 32'(stall_out), 32'(st));
            @(posedge clk); #1;
            if (st) stalls++;
            post(op, st, 32'd0);
        end
        if (req && rd) begin
            for (int k = 0; k <= rv_dly; k++) begin
                v = (k == rv_dly);
                @(negedge clk);
                drive(op, 1'b0, v, rdata);
                #1;
                check("wait_req", 32'(dmem_req), 32'd0);
                check("wait_be", 32'(dmem_be), 32'd0);
                check("wait_stall", 32'(stall_out), 32'(!v));
                @(posedge clk); #1;
                if (!v) stalls++;
                post(op, !v, v ? exp_load(op, rdata) : 32'd0);
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        op_t z, op;
        int  st;
        int  kind;
        z = '0;
        rst = 1'b1;
        drive(z, 1'b0, 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_alu", alu_result_out, 32'd0);
        check("rst_rw", 32'(reg_write_out), 32'd0);
        check("rst_mis", 32'(misalign_out), 32'd0);
        check("rst_data", mem_data_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Non-memory pass-through
        op = mk(32'h0000_0040, 32'h0000_1234, 32'h0, 3'b000, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(op, 0, 0, 32'h0, 1'b0, st);
        check("nonmem_stalls", 32'(st), 32'd0);
        check("nonmem_rd", 32'(rd_out), 32'd5);

        // SB zero-wait at 0x103
        op = mk(32'h0000_0044, 32'h0000_0103, 32'hAABB_CCDD, 3'b000, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(op, 0, 0, 32'h0, 1'b0, st);
        check("sb_stalls", 32'(st), 32'd0);

        // LB / LBU with rvalid one cycle after the grant cycle
        op = mk(32'h0000_0048, 32'h0000_0202, 32'h0, 3'b000, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        run_op(op, 0, 1, 32'h0080_0000, 1'b0, st);
        check("lb_stalls", 32'(st), 32'd2);
        check("lb_data", mem_data_out, 32'hFFFF_FF80);
        op.f3 = 3'b100;
        run_op(op, 0, 1, 32'h0080_0000, 1'b0, st);
        check("lbu_data", mem_data_out, 32'h0000_0080);

        // SW with grant withheld three cycles
        op = mk(32'h0000_004C, 32'h0000_0300, 32'h1357_9BDF, 3'b010, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(op, 3, 0, 32'h0, 1'b0, st);
        check("sw_stalls", 32'(st), 32'd3);

        // Misaligned LW at 0x06
        op = mk(32'h0000_0050, 32'h0000_0006, 32'h0, 3'b010, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        run_op(op, 0, 0, 32'h0, 1'b0, st);
        check("mis_stalls", 32'(st), 32'd0);
        check("mis_flag", 32'(misalign_out), 32'd1);

        // Reset while waiting for read data, then a late rvalid
        op = mk(32'h0000_0054, 32'h0000_0040, 32'h0, 3'b000, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        drive(op, 1'b1, 1'b0, 32'hDEAD_BEEF);
        #1;
        check("rstw_gnt_stall", 32'(stall_out), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(z, 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(z, 1'b0, 1'b1, 32'hDEAD_BEEF);
        #1;
        check("rstw_req", 32'(dmem_req), 32'd0);
        check("rstw_stall", 32'(stall_out), 32'd0);
        @(posedge clk); #1;
        check("rstw_data", mem_data_out, 32'd0);
        check("rstw_rw", 32'(reg_write_out), 32'd0);
        check("rstw_rd", 32'(rd_out), 32'd0);
        check("rstw_m2r", 32'(mem_to_reg_out), 32'd0);
        exp_alu_hold = '0;
        op = mk(32'h0000_0058, 32'h0000_0010, 32'h0000_00AA, 3'b000, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(op, 0, 0, 32'h0, 1'b0, st);
        check("rstw_idle_store", 32'(st), 32'd0);

        // Randomized operations
        for (int i = 0; i < 200; i++) begin
            kind      = int'($urandom_range(0, 3));
            op.pc     = $urandom;
            op.addr   = $urandom;
            op.rs2    = $urandom;
            op.rd     = 5'($urandom);
            op.wbs    = 2'($urandom);
            op.rw     = 1'($urandom);
            op.m2r    = 1'($urandom);
            op.rd_en  = (kind == 1) || (kind == 3);
            op.wr_en  = (kind == 2) || (kind == 3);
            op.f3     = (kind == 2) ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
            run_op(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                   ($urandom_range(0, 3) == 0), st);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
